// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse receive path
// Holds the FSM state encoding, the symbol record handed downstream,
// the AR prosign pattern and the gap/dash multipliers in Morse units.
package morse_pkg;
    localparam int MORSE_MAX_ELEMS = 6;
    localparam int MORSE_LEN_W     = $clog2(MORSE_MAX_ELEMS + 1);
    localparam logic [4:0] MORSE_AR_BITS = 5'b01010;
    localparam int MORSE_AR_LEN    = 5;
    localparam int CHAR_GAP_UNITS  = 2;
    localparam int WORD_GAP_UNITS  = 5;
    localparam int DASH_UNITS      = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE} state_t;
    typedef struct packed {
        logic [MORSE_MAX_ELEMS-1:0] bits;
        logic [MORSE_LEN_W-1:0]     len;
        logic                       word;
        logic                       err;
        logic                       msg_end;
    } morse_sym_t;
endpackage

// File: rtl/morse_rx_deglitch.sv
// morse_rx_deglitch: conditions the raw keyed line into the sampled level s
// Ports: i_clk, i_rst (async, active-high), i_data_morse (raw line), o_s (conditioned level).
// With MORSE_RX_DEGLITCH_EN defined: 2-FF synchronizer followed by a 3-sample
// majority vote (3 cycles latency). Otherwise a single register (1 cycle latency).
module morse_rx_deglitch (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_data_morse,
    output logic o_s
);
`ifdef MORSE_RX_DEGLITCH_EN
    logic [1:0] sync;
    logic [1:0] hist;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= '0;
            hist <= '0;
        end else begin
            sync <= {sync[0], i_data_morse};
            hist <= {hist[0], sync[1]};
        end
    end
    // vote over the newest synchronized sample and the two before it
    assign o_s = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
`else
    logic s_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) s_q <= 1'b0;
        else       s_q <= i_data_morse;
    end
    assign o_s = s_q;
`endif
endmodule

// File: rtl/morse_rx_ctrl.sv
// morse_rx_ctrl: Morse receive sequencer - classifies marks, assembles symbols, flags gaps and AR
// Ports: i_clk, i_rst (async, active-high), i_data_morse (keyed line),
//        o_sym_valid/i_sym_ready (symbol handshake), o_sym_bits, o_sym_len, o_sym_word,
//        o_sym_err, o_msg_end (symbol fields), o_overrun (sticky drop flag).
// Build option: MORSE_RX_DEGLITCH_EN enables the synchronizer/majority input filter.
module morse_rx_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 8,
    parameter int MAX_ELEMS   = 6,
    parameter int CNT_W       = $clog2(8 * UNIT_CYCLES),
    localparam int LEN_W      = $clog2(MAX_ELEMS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_data_morse,
    output logic                 o_sym_valid,
    input  logic                 i_sym_ready,
    output logic [MAX_ELEMS-1:0] o_sym_bits,
    output logic [LEN_W-1:0]     o_sym_len,
    output logic                 o_sym_word,
    output logic                 o_sym_err,
    output logic                 o_msg_end,
    output logic                 o_overrun
);
    localparam logic [CNT_W-1:0] GLITCH_T = CNT_W'(UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_T   = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_T   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);

    logic s, lvl, eerr, pend, valid_q, overrun_q;
    logic append, emit_char, emit_word, emit;
    logic [CNT_W-1:0] cnt;
    logic [MAX_ELEMS-1:0] ebits;
    logic [LEN_W-1:0] elen;
    state_t state, state_n;
    morse_sym_t sym_n, sym_q;

    morse_rx_deglitch u_deglitch (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data_morse (i_data_morse),
        .o_s          (s)
    );

    // cnt holds the length of the run of lvl that ended last cycle; when s
    // differs from lvl, cnt is the length of the run just finished
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else begin
            lvl <= s;
            cnt <= (s != lvl) ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
        end
    end

    always_comb begin
        append    = (state == ST_MARK) && !s && (cnt >= GLITCH_T);
        emit_char = (state == ST_SPACE) && (cnt == CHAR_T) && (elen != '0);
        emit_word = (state == ST_SPACE) && (cnt == WORD_T);
        emit      = emit_char | emit_word;
        // a glitch-only mark with nothing outstanding returns to IDLE so no word gap follows
        state_n   = state == ST_IDLE ? (s ? ST_MARK : ST_IDLE) :
                    state == ST_MARK ? (s ? ST_MARK : (append || pend) ? ST_SPACE : ST_IDLE) :
                    s ? ST_MARK : emit_word ? ST_IDLE : ST_SPACE;
        sym_n         = '0;
        sym_n.bits    = emit_word ? '0 : MORSE_MAX_ELEMS'(ebits);
        sym_n.len     = emit_word ? '0 : MORSE_LEN_W'(elen);
        sym_n.word    = emit_word;
        sym_n.err     = !emit_word && eerr;
        sym_n.msg_end = !emit_word && !eerr && (elen == LEN_W'(MORSE_AR_LEN))
                        && (ebits == MAX_ELEMS'(MORSE_AR_BITS));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ebits <= '0;
            elen  <= '0;
            eerr  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            if (emit_char) begin
                ebits <= '0;
                elen  <= '0;
                eerr  <= 1'b0;
            end else if (append && elen != LEN_W'(MAX_ELEMS)) begin
                ebits <= ebits | (MAX_ELEMS'(cnt >= DASH_T) << elen);
                elen  <= elen + 1'b1;
            end else if (append) begin
                eerr  <= 1'b1;
            end
            if (append)         pend <= 1'b1;
            else if (emit_word) pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            sym_q     <= '0;
            overrun_q <= 1'b0;
        end else if (emit && valid_q && !i_sym_ready) begin
            overrun_q <= 1'b1;
        end else if (emit) begin
            sym_q     <= sym_n;
            valid_q   <= 1'b1;
        end else if (valid_q && i_sym_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign o_sym_valid = valid_q;
    assign o_sym_bits  = MAX_ELEMS'(sym_q.bits);
    assign o_sym_len   = LEN_W'(sym_q.len);
    assign o_sym_word  = sym_q.word;
    assign o_sym_err   = sym_q.err;
    assign o_msg_end   = sym_q.msg_end;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_morse_rx_ctrl.sv
// tb_morse_rx_ctrl: directed and randomized self-checking bench for morse_rx_ctrl
module tb_morse_rx_ctrl;
    localparam int U = 4;
    localparam int ME = 6;

    typedef struct packed {
        logic [5:0] bits;
        logic [2:0] len;
        logic       word;
        logic       err;
        logic       me;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data = 1'b0;
    logic ready = 1'b0;
    logic valid, word, err, msg_end, overrun;
    logic [ME-1:0] bits;
    logic [2:0] len;
    int checks = 0;
    int errors = 0;
    bit mon = 1'b0;
    bit pend_m = 1'b0;
    exp_t exp_q[$];

    morse_rx_ctrl #(.UNIT_CYCLES(U), .MAX_ELEMS(ME)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_morse (data),
        .o_sym_valid  (valid),
        .i_sym_ready  (ready),
        .o_sym_bits   (bits),
        .o_sym_len    (len),
        .o_sym_word   (word),
        .o_sym_err    (err),
        .o_msg_end    (msg_end),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic d);
        exp_t e;
        data = d;
        @(posedge clk);
        #1;
        if (mon && valid && ready) begin
            if (exp_q.size() == 0) chk("rnd_extra_sym", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rnd_sym", {bits, len, word, err, msg_end}, e);
            end
        end
    endtask

    task automatic mark_space(input int m, input int sp);
        repeat (m) tick(1'b1);
        repeat (sp) tick(1'b0);
    endtask

    task automatic wait_sym(input string tag);
        int n = 0;
        while (!valid && n < 64) begin
            tick(1'b0);
            n++;
        end
        chk(tag, valid, 1);
    endtask

    task automatic check_sym(input string tag, input logic [5:0] b, input int l,
                             input logic w, input logic er, input logic m);
        chk(tag, {bits, len, word, err, msg_end}, {b, 3'(l), w, er, m});
    endtask

    task automatic flush();
        ready = 1'b1;
        repeat (30) tick(1'b0);
    endtask

    // reference: classify each mark length by unit thresholds, pack into a symbol
    task automatic rnd_char();
        int n, cnt, tg;
        int lens[8];
        int gaps[8];
        logic [5:0] b;
        logic er;
        n = $urandom_range(1, 8);
        cnt = 0;
        b = '0;
        er = 1'b0;
        for (int i = 0; i < n; i++) begin
            lens[i] = $urandom_range(1, 12);
            gaps[i] = $urandom_range(1, 2 * U - 1);
        end
        tg = ($urandom_range(0, 3) == 0) ? $urandom_range(5 * U, 5 * U + 6)
                                         : $urandom_range(2 * U, 5 * U - 1);
        for (int i = 0; i < n; i++) begin
            if (lens[i] >= U / 2) begin
                pend_m = 1'b1;
                if (cnt < ME) begin
                    b[cnt] = (lens[i] >= 2 * U);
                    cnt++;
                end else er = 1'b1;
            end
        end
        if (cnt > 0)
            exp_q.push_back({b, 3'(cnt), 1'b0, er, (cnt == 5 && b == 6'b001010 && !er)});
        if (tg >= 5 * U && pend_m) begin
            exp_q.push_back({6'b0, 3'd0, 1'b1, 1'b0, 1'b0});
            pend_m = 1'b0;
        end
        for (int i = 0; i < n; i++) mark_space(lens[i], (i == n - 1) ? tg : gaps[i]);
    endtask

    initial begin
        int v;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_fields", {bits, len, word, err, msg_end}, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        // dot: valid rises exactly 2U+2 ticks after the line falls
        mark_space(4, 9);
        chk("dot_valid_early", valid, 0);
        tick(1'b0);
        chk("dot_valid", valid, 1);
        check_sym("dot_fields", 6'b0, 1, 1'b0, 1'b0, 1'b0);
        ready = 1'b1;
        tick(1'b0);
        chk("dot_handshake", valid, 0);
        repeat (10) tick(1'b0);
        chk("word_valid_early", valid, 0);
        tick(1'b0);
        chk("word_valid", valid, 1);
        check_sym("word_fields", 6'b0, 0, 1'b1, 1'b0, 1'b0);
        flush();

        // K: dash dot dash
        ready = 1'b0;
        mark_space(12, 4);
        mark_space(4, 4);
        mark_space(12, 0);
        wait_sym("k_valid");
        check_sym("k_fields", 6'b000101, 3, 1'b0, 1'b0, 1'b0);
        flush();

        // AR prosign
        ready = 1'b0;
        mark_space(4, 4);
        mark_space(12, 4);
        mark_space(4, 4);
        mark_space(12, 4);
        mark_space(4, 0);
        wait_sym("ar_valid");
        check_sym("ar_fields", 6'b001010, 5, 1'b0, 1'b0, 1'b1);
        flush();

        // glitch only: no symbol at all
        v = 0;
        tick(1'b1);
        repeat (30) begin
            tick(1'b0);
            v += int'(valid);
        end
        chk("glitch_nosym", v, 0);

        // seven dots overflow
        ready = 1'b0;
        repeat (6) mark_space(4, 4);
        mark_space(4, 0);
        wait_sym("ovf_valid");
        check_sym("ovf_fields", 6'b0, 6, 1'b0, 1'b1, 1'b0);
        flush();

        // backpressure: E held while T and the word gap are dropped
        ready = 1'b0;
        mark_space(4, 0);
        wait_sym("bp_e_valid");
        check_sym("bp_e_fields", 6'b0, 1, 1'b0, 1'b0, 1'b0);
        mark_space(12, 9);
        chk("bp_overrun_early", overrun, 0);
        tick(1'b0);
        chk("bp_overrun", overrun, 1);
        check_sym("bp_held_t", 6'b0, 1, 1'b0, 1'b0, 1'b0);
        repeat (15) tick(1'b0);
        check_sym("bp_held_w", 6'b0, 1, 1'b0, 1'b0, 1'b0);
        chk("bp_valid_held", valid, 1);
        ready = 1'b1;
        tick(1'b0);
        chk("bp_release", valid, 0);
        chk("bp_overrun_sticky", overrun, 1);

        // reset mid-mark
        repeat (5) tick(1'b1);
        rst = 1'b1;
        #2;
        chk("mrst_valid", valid, 0);
        chk("mrst_fields", {bits, len, word, err, msg_end}, 0);
        chk("mrst_overrun", overrun, 0);
        rst = 1'b0;
        v = 0;
        tick(1'b1);
        repeat (12) begin
            tick(1'b0);
            v += int'(valid);
        end
        chk("mrst_nosym", v, 0);
        ready = 1'b0;
        mark_space(4, 0);
        wait_sym("mrst_dot_valid");
        check_sym("mrst_dot_fields", 6'b0, 1, 1'b0, 1'b0, 1'b0);
        flush();

        // randomized characters against the reference model
        mon = 1'b1;
        ready = 1'b1;
        pend_m = 1'b0;
        repeat (40) rnd_char();
        if (pend_m) exp_q.push_back({6'b0, 3'd0, 1'b1, 1'b0, 1'b0});
        repeat (30) tick(1'b0);
        chk("rnd_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/morse_rx_ctrl.md
# morse_rx_ctrl

Front-end sequencer for the Morse receive path. Samples the raw keyed line, measures mark and space run lengths against a configurable unit time, and classifies each mark as dot or dash. It assembles elements into character symbols and hands them to the downstream character decoder/message buffer over a valid/ready handshake. It also flags word gaps and the end-of-message prosign (AR, `.-.-.`).

## Interface
Parameters:
- UNIT_CYCLES, 8: clock cycles per Morse unit (dot length); must be ≥ 2.
- MAX_ELEMS, 6: maximum elements per character.
- CNT_W, $clog2(8*UNIT_CYCLES): run-length counter width (derived).

Ports:
- i_clk  in  1  clock, single domain; all logic on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_data_morse  in  1  raw keyed line; 1 = key down (mark).
- o_sym_valid  out  1  symbol available.
- i_sym_ready  in  1  downstream accepts the symbol.
- o_sym_bits  out  MAX_ELEMS  element pattern; bit 0 = first element; 1 = dash, 0 = dot; unused bits 0.
- o_sym_len  out  $clog2(MAX_ELEMS+1)  element count; 0 for a word-gap symbol.
- o_sym_word  out  1  symbol is a word-gap marker.
- o_sym_err  out  1  character exceeded MAX_ELEMS elements.
- o_msg_end  out  1  symbol is AR (len 5, bits 5'b01010).
- o_overrun  out  1  sticky: a symbol was dropped while the output register was full.

## Operation
- Conditioned input `s` is the registered i_data_morse (see Configuration).
- FSM states:
  - IDLE: line low, no elements pending, word gap already reported or reset.
  - MARK: counting high cycles.
  - SPACE: counting low cycles after at least one element.
- Run counter:
  - Loads 1 on each level change; increments each cycle of the same level.
  - Saturates at 2^CNT_W−1.
- Transitions:
  - IDLE→MARK on s=1.
  - MARK→SPACE on s=0. Classify the finished mark by its length L in cycles:
    - L < UNIT_CYCLES/2: glitch, discarded; no element appended, space count restarts.
    - UNIT_CYCLES/2 ≤ L < 2*UNIT_CYCLES: dot.
    - L ≥ 2*UNIT_CYCLES: dash.
  - SPACE→MARK on s=1.
  - SPACE→IDLE when the space count reaches 5*UNIT_CYCLES.
- Character gap: space count == 2*UNIT_CYCLES with elements pending → emit character symbol, clear the element buffer.
- Word gap: space count == 5*UNIT_CYCLES → emit a word symbol (o_sym_word=1, len 0) once, then go to IDLE. A glitch-only mark never produces a symbol.
- Overflow: elements beyond MAX_ELEMS are discarded and set err; len saturates at MAX_ELEMS.
- o_msg_end is set with the symbol when len==5 and bits==5'b01010 and err=0.
- Output register:
  - Symbol fields are stable while o_sym_valid=1.
  - Transfer occurs on a cycle with valid & ready.
  - Emit while the register is full and not transferring in the same cycle: the new symbol is dropped and o_overrun is set.
  - Emit in the same cycle as a transfer: the new symbol is loaded; no overrun.
- Reset values: o_sym_valid=0, o_sym_bits=0, o_sym_len=0, o_sym_word=0, o_sym_err=0, o_msg_end=0, o_overrun=0; FSM IDLE; counters and element buffer 0.
- Reset mid-character discards the pending elements and any held symbol.

## Timing
- Input path latency: 1 cycle without the macro, 3 cycles with it.
- Element classification happens on the first s=0 cycle. The element is visible in the buffer the following cycle.
- o_sym_valid rises one cycle after the space counter equals the threshold (2*UNIT_CYCLES or 5*UNIT_CYCLES).
- o_sym_valid falls the cycle after a valid & ready handshake unless a new symbol loads.
- o_overrun clears only on i_rst.

## Configuration
- MORSE_RX_DEGLITCH_EN defined:
  - i_data_morse passes through a 2-FF synchronizer, then a 3-sample majority vote; s changes only when 2 of 3 samples agree.
  - Input latency is 3 cycles.
- MORSE_RX_DEGLITCH_EN undefined:
  - Single input register, 1 cycle latency.
  - Assumes i_data_morse is synchronous to i_clk.
- The mark-length glitch rule applies in both builds.

## Structure
- Shared package morse_pkg holds:
  - typedef morse_sym_t (bits, len, word, err, msg_end).
  - Constants MORSE_AR_BITS=5'b01010 and MORSE_AR_LEN=5.
  - Gap multipliers CHAR_GAP_UNITS=2, WORD_GAP_UNITS=5, DASH_UNITS=2.
- One sub-module, morse_rx_deglitch: input synchronizer and majority filter, generated only under the macro; bypass register otherwise.
- FSM, counter, element buffer and output register stay in morse_rx_ctrl.

## Test plan
All scenarios use UNIT_CYCLES=4 and the macro undefined.
- Dot: high 4 cycles, then low 8 cycles → one symbol: len=1, bits=0, word=0; after ready, low to 20 total → word symbol len=0, word=1.
- Dash-dot-dash (K): marks of 12/4/12 cycles, gaps of 4, then low 8 → len=3, bits=3'b101, msg_end=0.
- AR: marks 4/12/4/12/4 cycles, gaps 4, then low 8 → len=5, bits=5'b01010, msg_end=1.
- Glitch plus overflow: 1-cycle high pulse → no element, no symbol; seven dots → len=6, err=1, bits=0.
- Backpressure: i_sym_ready=0; send `E`, then `T`, then a word gap → first symbol held unchanged; o_overrun=1 after the `T` emit; releasing ready transfers `E`.
- Reset mid-mark: i_rst pulsed during a 6-cycle high → all outputs 0 immediately; after a subsequent dot plus 8 low cycles, a clean len=1 symbol is produced.
